neuron_update_scheduler: RTL and testbench



---
 rtl/neuron_update_scheduler.sv | 160 ++++++++++++++++
 tb/tb_neuron_update_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_update_scheduler.sv
// Per-timestep neuron sweep: fetches each neuron's currents, fires the update
// engine, collects spike results and raises done (or a timeout) at the end.
module neuron_update_scheduler #(
  parameter int N_NEURON = 18,
  parameter int IDX_W    = 5,
  parameter int CUR_W    = 25,
  parameter int TIMEOUT  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic                    i_cnt_clr_req,
  output logic                    o_cur_rd,
  output logic [IDX_W-1:0]        o_cur_addr,
  input  logic signed [CUR_W-1:0] i_exc_cur,
  input  logic signed [CUR_W-1:0] i_inh_cur,
  output logic                    o_run,
  output logic signed [CUR_W-1:0] o_exc_current,
  output logic signed [CUR_W-1:0] o_inh_current,
  input  logic                    i_valid,
  input  logic                    i_spike,
  input  logic [IDX_W-1:0]        i_neuron_idx,
  output logic                    o_cnt_clr,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [N_NEURON-1:0]     o_spike_vec,
  output logic [IDX_W-1:0]        o_spike_cnt,
  output logic                    o_err_timeout,
  output logic                    o_err_idx
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURON - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_RUN, S_WAIT, S_GAP, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        addr_q, addr_d;
  logic [TO_W-1:0]         wcnt_q, wcnt_d;
  logic signed [CUR_W-1:0] exc_q, exc_d;
  logic signed [CUR_W-1:0] inh_q, inh_d;
  logic [N_NEURON-1:0]     vec_q, vec_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    err_to_q, err_to_d;
  logic                    err_idx_q, err_idx_d;
  logic                    clr_q, clr_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wcnt_d    = wcnt_q;
    exc_d     = exc_q;
    inh_d     = inh_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_to_d  = err_to_q;
    err_idx_d = err_idx_q;
    clr_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        clr_d = i_cnt_clr_req;
        if (i_start) begin
          state_d   = S_FETCH;
          idx_d     = '0;
          addr_d    = '0;
          vec_d     = '0;
          cnt_d     = '0;
          err_to_d  = 1'b0;
          err_idx_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        exc_d   = i_exc_cur;
        inh_d   = i_inh_cur;
        state_d = S_RUN;
      end
      S_RUN: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_valid) begin
          // Result lands at our own idx even if the engine reports another one.
          for (int i = 0; i < N_NEURON; i++) begin
            if (idx_q == IDX_W'(i)) vec_d[i] = i_spike;
          end
          if (i_spike) cnt_d = cnt_q + 1'b1;
          if (i_neuron_idx != idx_q) err_idx_d = 1'b1;
          state_d = S_GAP;
        end else if (wcnt_q == TO_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          addr_d  = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      wcnt_q    <= '0;
      exc_q     <= '0;
      inh_q     <= '0;
      vec_q     <= '0;
      cnt_q     <= '0;
      err_to_q  <= 1'b0;
      err_idx_q <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      wcnt_q    <= wcnt_d;
      exc_q     <= exc_d;
      inh_q     <= inh_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      err_to_q  <= err_to_d;
      err_idx_q <= err_idx_d;
      clr_q     <= clr_d;
    end
  end

  // Strobes decode straight from the state register, so they are glitch-free
  // single-cycle pulses aligned with the state they belong to.
  assign o_cur_rd      = (state_q == S_FETCH);
  assign o_run         = (state_q == S_RUN);
  assign o_done        = (state_q == S_DONE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_cur_addr    = addr_q;
  assign o_exc_current = exc_q;
  assign o_inh_current = inh_q;
  assign o_cnt_clr     = clr_q;
  assign o_spike_vec   = vec_q;
  assign o_spike_cnt   = cnt_q;
  assign o_err_timeout = err_to_q;
  assign o_err_idx     = err_idx_q;

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Randomized bench for neuron_update_scheduler: a behavioural current buffer and
// engine drive the DUT; expected timing and results come from per-neuron latencies.
module tb_neuron_update_scheduler;

  localparam int N  = 18;
  localparam int IW = 5;
  localparam int CW = 25;
  localparam int TO = 64;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 i_start = 1'b0;
  logic                 i_cnt_clr_req = 1'b0;
  logic                 o_cur_rd;
  logic [IW-1:0]        o_cur_addr;
  logic signed [CW-1:0] i_exc_cur = '0;
  logic signed [CW-1:0] i_inh_cur = '0;
  logic                 o_run;
  logic signed [CW-1:0] o_exc_current;
  logic signed [CW-1:0] o_inh_current;
  logic                 i_valid = 1'b0;
  logic                 i_spike = 1'b0;
  logic [IW-1:0]        i_neuron_idx = '0;
  logic                 o_cnt_clr;
  logic                 o_busy;
  logic                 o_done;
  logic [N-1:0]         o_spike_vec;
  logic [IW-1:0]        o_spike_cnt;
  logic                 o_err_timeout;
  logic                 o_err_idx;

  neuron_update_scheduler #(
    .N_NEURON(N), .IDX_W(IW), .CUR_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_cnt_clr_req(i_cnt_clr_req),
    .o_cur_rd(o_cur_rd), .o_cur_addr(o_cur_addr),
    .i_exc_cur(i_exc_cur), .i_inh_cur(i_inh_cur),
    .o_run(o_run), .o_exc_current(o_exc_current), .o_inh_current(o_inh_current),
    .i_valid(i_valid), .i_spike(i_spike), .i_neuron_idx(i_neuron_idx),
    .o_cnt_clr(o_cnt_clr), .o_busy(o_busy), .o_done(o_done),
    .o_spike_vec(o_spike_vec), .o_spike_cnt(o_spike_cnt),
    .o_err_timeout(o_err_timeout), .o_err_idx(o_err_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Scenario configuration
  int                   lat[N];
  bit                   spk[N];
  logic signed [CW-1:0] exc_val[32];
  logic signed [CW-1:0] inh_val[32];
  int                   tout_at = -1;
  int                   badidx_at = -1;
  bit                   stray = 1'b0;
  bit                   mid_start = 1'b0;

  // Environment state and recorded events
  int                   t_start = 0;
  int                   n_run = 0;
  bit                   pend = 1'b0;
  int                   pend_at = 0;
  int                   pend_idx = 0;
  bit                   pend_spk = 1'b0;
  int                   mj;
  int                   run_t[$];
  logic signed [CW-1:0] run_exc[$];
  logic signed [CW-1:0] run_inh[$];
  int                   fetch_addr[$];
  int                   done_t[$];
  int                   clr_t[$];

  // Current buffer and update engine models; inputs change on the falling edge.
  always @(negedge clk) begin
    i_valid      = 1'b0;
    i_spike      = 1'($urandom_range(1));
    i_neuron_idx = IW'($urandom_range(31));
    if (pend && cyc == pend_at) begin
      i_valid      = 1'b1;
      i_spike      = pend_spk;
      i_neuron_idx = IW'(pend_idx);
      pend         = 1'b0;
    end else if (stray && o_cur_rd) begin
      i_valid      = 1'b1;
      i_spike      = 1'b1;
      i_neuron_idx = o_cur_addr;
    end
    if (o_cur_rd) begin
      fetch_addr.push_back(int'(o_cur_addr));
      i_exc_cur = exc_val[o_cur_addr];
      i_inh_cur = inh_val[o_cur_addr];
    end
    if (o_run) begin
      mj = n_run;
      n_run++;
      run_t.push_back(cyc - t_start);
      run_exc.push_back(o_exc_current);
      run_inh.push_back(o_inh_current);
      if (mj < N && mj != tout_at) begin
        pend     = 1'b1;
        pend_at  = cyc + lat[mj];
        pend_idx = (mj == badidx_at) ? (mj + 1) % 32 : mj;
        pend_spk = spk[mj];
      end
    end
    if (o_done) done_t.push_back(cyc - t_start);
    if (o_cnt_clr) clr_t.push_back(cyc);
  end

  task automatic cfg_default();
    for (int j = 0; j < N; j++) begin
      lat[j] = 3;
      spk[j] = 1'b0;
    end
    for (int j = 0; j < 32; j++) begin
      exc_val[j] = CW'(2000 + 2000 * j);
      inh_val[j] = '0;
    end
    tout_at   = -1;
    badidx_at = -1;
    stray     = 1'b0;
    mid_start = 1'b0;
  endtask

  task automatic cfg_random();
    for (int j = 0; j < N; j++) begin
      lat[j] = $urandom_range(6, 1);
      spk[j] = 1'($urandom_range(1));
    end
    for (int j = 0; j < 32; j++) begin
      exc_val[j] = CW'($urandom);
      inh_val[j] = CW'($urandom);
    end
    tout_at   = ($urandom_range(2) == 0) ? int'($urandom_range(N - 1)) : -1;
    badidx_at = ($urandom_range(1) == 0) ? int'($urandom_range(N - 1)) : -1;
    stray     = 1'($urandom_range(1));
    mid_start = 1'($urandom_range(1));
  endtask

  task automatic clear_records();
    run_t.delete();
    run_exc.delete();
    run_inh.delete();
    fetch_addr.delete();
    done_t.delete();
    clr_t.delete();
    n_run = 0;
    pend  = 1'b0;
  endtask

  // One full sweep compared against the latency-sum model of the scheduler.
  task automatic do_sweep(input string nm);
    int           exp_nrun, exp_done, acc, budget, exp_cnt, nr;
    int           exp_run[$];
    logic [N-1:0] exp_vec;
    bit           exp_eidx;
    clear_records();
    exp_nrun = (tout_at >= 0) ? tout_at + 1 : N;
    acc      = 3;
    exp_vec  = '0;
    exp_cnt  = 0;
    exp_done = 0;
    for (int j = 0; j < exp_nrun; j++) begin
      exp_run.push_back(acc);
      if (j == tout_at) begin
        exp_done = acc + TO + 1;
      end else begin
        if (spk[j]) begin
          exp_vec[j] = 1'b1;
          exp_cnt++;
        end
        acc += lat[j] + 4;
      end
    end
    if (tout_at < 0) exp_done = acc - 2;
    exp_eidx = (badidx_at >= 0) && (badidx_at < exp_nrun) && (badidx_at != tout_at);

    @(negedge clk);
    i_start = 1'b1;
    t_start = cyc;
    budget  = 0;
    do begin
      @(negedge clk);
      i_start = (mid_start && ((cyc - t_start) == 40 || (cyc - t_start) == exp_done));
      #1;
      budget++;
    end while (done_t.size() == 0 && budget < 4000);

    chk({nm, "_done_seen"}, done_t.size() > 0, 1'b1);
    if (done_t.size() > 0) chk({nm, "_done_cycle"}, done_t[0], exp_done);
    chk({nm, "_spike_vec"}, o_spike_vec, exp_vec);
    chk({nm, "_spike_cnt"}, o_spike_cnt, exp_cnt);
    chk({nm, "_err_timeout"}, o_err_timeout, tout_at >= 0);
    chk({nm, "_err_idx"}, o_err_idx, exp_eidx);
    chk({nm, "_run_count"}, run_t.size(), exp_nrun);
    nr = (run_t.size() < exp_nrun) ? run_t.size() : exp_nrun;
    for (int j = 0; j < nr; j++) begin
      chk($sformatf("%s_run_cycle_%0d", nm, j), run_t[j], exp_run[j]);
      chk($sformatf("%s_exc_%0d", nm, j), run_exc[j], exc_val[j]);
      chk($sformatf("%s_inh_%0d", nm, j), run_inh[j], inh_val[j]);
    end
    chk({nm, "_fetch_count"}, fetch_addr.size(), exp_nrun);
    for (int j = 0; j < fetch_addr.size() && j < exp_nrun; j++)
      chk($sformatf("%s_fetch_addr_%0d", nm, j), fetch_addr[j], j);

    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    #1;
    chk({nm, "_idle_after"}, o_busy, 1'b0);
    chk({nm, "_done_once"}, done_t.size(), 1);
    chk({nm, "_vec_hold"}, o_spike_vec, exp_vec);
    chk({nm, "_cnt_hold"}, o_spike_cnt, exp_cnt);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {o_cur_rd, o_cur_addr, o_run, o_cnt_clr, o_busy, o_done,
                       o_err_timeout, o_err_idx}, '0);
    chk({nm, "_exc"}, o_exc_current, '0);
    chk({nm, "_inh"}, o_inh_current, '0);
    chk({nm, "_vec"}, o_spike_vec, '0);
    chk({nm, "_cnt"}, o_spike_cnt, '0);
  endtask

  initial begin
    int budget, tc;
    cfg_default();
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    cfg_default();
    do_sweep("normal");

    cfg_default();
    spk[0] = 1'b1; spk[5] = 1'b1; spk[17] = 1'b1;
    do_sweep("spikes");
    chk("spikes_bitmap_literal", o_spike_vec, 18'h20021);

    cfg_default();
    tout_at = 4;
    do_sweep("timeout");

    cfg_default();
    badidx_at = 6;
    do_sweep("badidx");

    cfg_default();
    stray = 1'b1;
    mid_start = 1'b1;
    do_sweep("ignored");

    for (int r = 0; r < 5; r++) begin
      cfg_random();
      do_sweep($sformatf("rand%0d", r));
    end

    // Reset mid-sweep at neuron 9, with a clear request while busy that must be ignored.
    cfg_default();
    clear_records();
    @(negedge clk);
    i_start = 1'b1;
    t_start = cyc;
    budget  = 0;
    do begin
      @(negedge clk);
      i_start = 1'b0;
      i_cnt_clr_req = ((cyc - t_start) == 20);
      #1;
      budget++;
    end while (n_run < 10 && budget < 2000);
    chk("rst_reached_n9", n_run, 10);
    i_cnt_clr_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_zero("midrst");
    reset = 1'b0;
    repeat (150) @(negedge clk);
    #1;
    chk("midrst_no_done", done_t.size(), 0);
    chk("midrst_busy_clr_ignored", clr_t.size(), 0);
    chk("midrst_vec_after", o_spike_vec, '0);
    chk("midrst_cnt_after", o_spike_cnt, '0);

    @(negedge clk);
    i_cnt_clr_req = 1'b1;
    tc = cyc;
    @(negedge clk);
    i_cnt_clr_req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("cnt_clr_pulses", clr_t.size(), 1);
    if (clr_t.size() > 0) chk("cnt_clr_cycle", clr_t[0], tc + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
